// File: rtl/fp_normalize_round_pipe.sv
// fp_normalize_round_pipe
//   Two-stage normalize/round pipeline placed after the FP adder's align/add
//   stage. Stage 1 normalizes the aligned sum: a carry-out shifts it right,
//   leading zeros shift it left, and gradual underflow produces subnormals.
//   Stage 2 rounds to MAN_W bits in one of four modes, detects overflow and
//   registers the packed IEEE-754 result together with its exception flags.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  upstream handshake
//   in_sign, in_exp    sign and biased exponent of the aligned sum
//   in_mant, in_carry  aligned magnitude (hidden bit at ACC_W-1) and carry-out
//   in_special(_val)   bypass a precomputed NaN/Inf/zero result
//   rmode              0 RNE, 1 RTZ, 2 toward +inf, 3 toward -inf
//   out_valid/out_ready downstream handshake
//   out_result         {sign, exponent, mantissa}
//   out_overflow, out_underflow, out_inexact  exception flags
module fp_normalize_round_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int ACC_W = MAN_W + 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_W-1:0]       in_exp,
  input  logic [ACC_W-1:0]       in_mant,
  input  logic                   in_carry,
  input  logic                   in_special,
  input  logic [EXP_W+MAN_W:0]   in_special_val,
  input  logic [1:0]             rmode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result,
  output logic                   out_overflow,
  output logic                   out_underflow,
  output logic                   out_inexact
);

  localparam int RES_W = 1 + EXP_W + MAN_W;
  // Two extra bits so exponent arithmetic can go past all-ones or below zero.
  localparam int XW    = EXP_W + 2;
  localparam int LZ_W  = $clog2(ACC_W + 1);
  localparam logic [XW-1:0] EXP_INF = XW'((1 << EXP_W) - 1);

  function automatic logic [LZ_W-1:0] lzc(input logic [ACC_W-1:0] v);
    logic [LZ_W-1:0] n;
    n = LZ_W'(ACC_W);
    for (int i = 0; i < ACC_W; i++) begin
      if (v[i]) n = LZ_W'(ACC_W - 1 - i);
    end
    return n;
  endfunction

  // ---------------- stage 1: normalize ----------------
  logic             s1Valid, s1Sign, s1Sub, s1Special;
  logic [XW-1:0]    s1Exp;
  logic [ACC_W-1:0] s1Mant;
  logic [RES_W-1:0] s1SpecialVal;
  logic [1:0]       s1Rmode;

  logic             nSub, nSpecial;
  logic [XW-1:0]    nExp, expNorm;
  logic [ACC_W-1:0] nMant;
  logic [RES_W-1:0] nSpecialVal;
  logic [LZ_W-1:0]  lz;
  logic [EXP_W-1:0] subShift;

  always_comb begin
    nSub        = 1'b0;
    nSpecial    = 1'b0;
    nSpecialVal = in_special_val;
    nExp        = '0;
    nMant       = in_mant;
    lz          = lzc(in_mant);
    expNorm     = {2'b00, in_exp} - XW'(lz);
    subShift    = (in_exp != '0) ? in_exp - EXP_W'(1) : '0;
    if (in_special) begin
      nSpecial = 1'b1;
    end else if (in_carry) begin
      // The bit shifted out lands in the sticky region, so fold it into bit 0.
      nMant = {1'b1, in_mant[ACC_W-1:2], |in_mant[1:0]};
      nExp  = {2'b00, in_exp} + XW'(1);
    end else if (in_mant == '0) begin
      // An exact zero is just another pass-through value.
      nSpecial    = 1'b1;
      nSpecialVal = {in_sign, {(RES_W-1){1'b0}}};
    end else if (!expNorm[XW-1] && expNorm != '0) begin
      nMant = in_mant << lz;
      nExp  = expNorm;
    end else begin
      nMant = in_mant << subShift;
      nSub  = 1'b1;
    end
  end

  // ---------------- stage 2: round ----------------
  logic [MAN_W-1:0] field;
  logic [MAN_W:0]   fieldInc;
  logic             guardBit, roundBit, stickyBit, lost, inc, away, ovf;
  logic [XW-1:0]    expRnd;
  logic [RES_W-1:0] nResult;
  logic             nOvf, nUnf, nInx;

  always_comb begin
    field     = s1Mant[ACC_W-2 -: MAN_W];
    guardBit  = s1Mant[ACC_W-2-MAN_W];
    roundBit  = s1Mant[ACC_W-3-MAN_W];
    stickyBit = |s1Mant[ACC_W-4-MAN_W:0];
    lost      = guardBit | roundBit | stickyBit;
    case (s1Rmode)
      2'd0:    inc = guardBit & (roundBit | stickyBit | field[0]);
      2'd2:    inc = !s1Sign & lost;
      2'd3:    inc = s1Sign & lost;
      default: inc = 1'b0;
    endcase
    away     = (s1Rmode == 2'd0) | ((s1Rmode == 2'd2) & !s1Sign) | ((s1Rmode == 2'd3) & s1Sign);
    fieldInc = {1'b0, field} + {{MAN_W{1'b0}}, inc};
    // Subnormals sit at exponent 0; the hidden bit (already set, or reached
    // by rounding) promotes them to exponent 1.
    expRnd   = s1Exp + XW'(s1Sub & s1Mant[ACC_W-1]) + XW'(fieldInc[MAN_W]);
    ovf      = expRnd >= EXP_INF;
    nOvf     = 1'b0;
    nUnf     = 1'b0;
    nInx     = 1'b0;
    if (s1Special) begin
      nResult = s1SpecialVal;
    end else if (ovf) begin
      nOvf    = 1'b1;
      nInx    = 1'b1;
      nUnf    = s1Sub & lost;
      nResult = away ? {s1Sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                     : {s1Sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    end else begin
      nInx    = lost;
      nUnf    = s1Sub & lost;
      nResult = {s1Sign, expRnd[EXP_W-1:0], fieldInc[MAN_W-1:0]};
    end
  end

  // ---------------- handshake and registers ----------------
  logic s2Free;
  assign s2Free   = !out_valid || out_ready;
  assign in_ready = !s1Valid || s2Free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid       <= 1'b0;
      s1Sign        <= 1'b0;
      s1Sub         <= 1'b0;
      s1Special     <= 1'b0;
      s1Exp         <= '0;
      s1Mant        <= '0;
      s1SpecialVal  <= '0;
      s1Rmode       <= '0;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_inexact   <= 1'b0;
    end else begin
      if (in_ready) begin
        s1Valid <= in_valid;
        if (in_valid) begin
          s1Sign       <= in_sign;
          s1Sub        <= nSub;
          s1Special    <= nSpecial;
          s1Exp        <= nExp;
          s1Mant       <= nMant;
          s1SpecialVal <= nSpecialVal;
          s1Rmode      <= rmode;
        end
      end
      if (s2Free) begin
        out_valid <= s1Valid;
        if (s1Valid) begin
          out_result    <= nResult;
          out_overflow  <= nOvf;
          out_underflow <= nUnf;
          out_inexact   <= nInx;
        end
      end
    end
  end

endmodule
